// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle phase sequencer emitting one-hot per-stage clock enables.
// Holds EX on the extension ALU and MA on the MMU, skips MA for non-memory instructions,
// and adds a stall watchdog and a halt/resume handshake at the instruction boundary.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycleCnt/instretCnt performance counters.
module stage_sequencer #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned EX_STAGE   = 2,
    parameter int unsigned MA_STAGE   = 3,
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rwmem,
    input  logic                  memWait,
    input  logic                  exReq,
    input  logic                  exBusy,
    input  logic                  haltReq,
    output logic [NUM_STAGES-1:0] stageEn,
    output logic                  stageFirst,
    output logic                  retire,
    output logic                  halted,
    output logic                  wdFault
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [63:0]           cycleCnt,
    output logic [63:0]           instretCnt
`endif
);

    localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [SW-1:0]    EX_IDX   = SW'(EX_STAGE);
    localparam logic [SW-1:0]    MA_IDX   = SW'(MA_STAGE);
    localparam logic [SW-1:0]    MA_PREV  = SW'(MA_STAGE - 1);
    localparam logic [SW-1:0]    MA_NEXT  = SW'(MA_STAGE + 1);
    localparam logic [SW-1:0]    LAST_IDX = SW'(NUM_STAGES - 1);
    // Hold cycles allowed before the stage is forced on; a stage lasts at most WAIT_LIMIT+1 cycles.
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(WAIT_LIMIT);

    typedef enum logic {ModeRun, ModeHalted} mode_e;

    mode_e            mode_q, mode_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             first_q, first_d;
    logic             wd_q, wd_d;
    logic             hold;
    logic             wd_force;

    // State register with synchronous reset; reset abandons any in-flight instruction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q     <= ModeRun;
            stage_q    <= '0;
            hold_cnt_q <= '0;
            first_q    <= 1'b1;
            wd_q       <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            stage_q    <= stage_d;
            hold_cnt_q <= hold_cnt_d;
            first_q    <= first_d;
            wd_q       <= wd_d;
        end
    end

    // Next-state: stage hold/advance, MA skip, watchdog force, halt at retire and resume.
    always_comb begin
        mode_d     = mode_q;
        stage_d    = stage_q;
        hold_cnt_d = hold_cnt_q;
        first_d    = 1'b0;
        wd_d       = wd_q;
        hold       = 1'b0;
        wd_force   = 1'b0;
        retire     = 1'b0;
        unique case (mode_q)
            ModeRun: begin
                if (stage_q == EX_IDX) begin
                    // first_q term guarantees at least one extra EX cycle for the ALU to respond
                    hold = exReq & (first_q | exBusy);
                end else if (stage_q == MA_IDX) begin
                    hold = memWait;
                end
                wd_force = hold && (hold_cnt_q == HOLD_MAX);
                if (!hold || wd_force) begin
                    hold_cnt_d = '0;
                    first_d    = 1'b1;
                    if ((stage_q == MA_PREV) && !rwmem) begin
                        stage_d = MA_NEXT;
                    end else if (stage_q == LAST_IDX) begin
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                    if (stage_q == LAST_IDX) begin
                        retire = 1'b1;
                        if (haltReq) begin
                            mode_d  = ModeHalted;
                            stage_d = '0;
                        end
                    end
                    if (wd_force) begin
                        wd_d = 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ModeHalted: begin
                stage_d    = '0;
                hold_cnt_d = '0;
                if (!haltReq) begin
                    mode_d  = ModeRun;
                    first_d = 1'b1;
                end
            end
            default: begin
                mode_d = ModeRun;
            end
        endcase
    end

    // Output decode: one-hot enable of the active stage, suppressed while parked.
    always_comb begin
        stageEn = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            stageEn[i] = (mode_q == ModeRun) && (stage_q == SW'(i));
        end
        stageFirst = first_q && (mode_q == ModeRun);
        halted     = (mode_q == ModeHalted);
        wdFault    = wd_q;
    end

`ifdef SEQ_PERF_CNT_EN
    // Performance counters: active cycles and retired instructions, free-running modulo 2**64.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycleCnt   <= '0;
            instretCnt <= '0;
        end else begin
            if (mode_q == ModeRun) begin
                cycleCnt <= cycleCnt + 64'd1;
            end
            if (retire) begin
                instretCnt <= instretCnt + 64'd1;
            end
        end
    end
`endif

endmodule
